fight_data_control: RTL

FIGHT_DATA_CONTROL -- requirements
Module: fight_data_control

---
 rtl/fight_pkg.sv | 38 +++
 rtl/fight_data_control_attack_timer.sv | 30 +++
 rtl/fight_data_control.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fight_pkg.sv
// Shared constants and types for the fight stage: scene codes, key-press
// vectors, FSM state encoding, winner codes and an HP arithmetic helper.
package fight_pkg;

    // Scene codes driven by the top-level scene sequencer
    localparam logic [3:0] SCENE_START  = 4'b0001;
    localparam logic [3:0] SCENE_CHOOSE = 4'b0010;
    localparam logic [3:0] SCENE_FIGHT  = 4'b0011;
    localparam logic [3:0] SCENE_WIN    = 4'b0100;

    // Key vectors ordered {U, D, L, R, C}; only exact one-hot values are commands
    localparam logic [4:0] PRESS_U = 5'b10000;
    localparam logic [4:0] PRESS_D = 5'b01000;
    localparam logic [4:0] PRESS_L = 5'b00100;
    localparam logic [4:0] PRESS_R = 5'b00010;
    localparam logic [4:0] PRESS_C = 5'b00001;

    // Winner codes
    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;

    // Fight FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SELECT = 3'd2,
        ST_ATTACK = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } fight_state_t;

    // HP minus damage, clamped at zero so a large hit never wraps
    function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
        return (hp > dmg) ? (hp - dmg) : 8'd0;
    endfunction

endpackage

// File: rtl/fight_data_control_attack_timer.sv
// Attack-hold timer: a start pulse arms a down-counter so that done is high
// on the ATTACK_CYCLES-th cycle after the start edge.
module attack_timer #(
    parameter int unsigned ATTACK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int unsigned W = $clog2(ATTACK_CYCLES + 1);

    logic [W-1:0] count;

    // Load the hold length on start, then count down to zero and park there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= W'(ATTACK_CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Count reads ATTACK_CYCLES on the first held cycle and 1 on the last
    assign done = (count == W'(1));

endmodule

// File: rtl/fight_data_control.sv
// Fight-stage controller: loads both players' stats, lets the active player
// pick a skill with the keys, holds each attack for display, applies damage
// and declares the winner.
module fight_data_control
    import fight_pkg::*;
#(
    parameter int unsigned ATTACK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] scene_state,
    input  logic       key_U,
    input  logic       key_D,
    input  logic       key_L,
    input  logic       key_R,
    input  logic       key_C,
    input  logic [7:0] p1_pokemon_hp,
    input  logic [7:0] p1_pokemon_speed,
    input  logic [7:0] p1_skill_1_damage,
    input  logic [7:0] p1_skill_2_damage,
    input  logic [7:0] p1_skill_3_damage,
    input  logic [7:0] p2_pokemon_hp,
    input  logic [7:0] p2_pokemon_speed,
    input  logic [7:0] p2_skill_1_damage,
    input  logic [7:0] p2_skill_2_damage,
    input  logic [7:0] p2_skill_3_damage,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic       turn,
    output logic [1:0] skill_cursor,
    output logic [7:0] last_damage,
    output logic       attacking,
    output logic [1:0] winner,
    output logic       fight_done
);

    fight_state_t state;

    // Skill damages captured at LOAD so later input changes are invisible
    logic [7:0] p1_dmg_1, p1_dmg_2, p1_dmg_3;
    logic [7:0] p2_dmg_1, p2_dmg_2, p2_dmg_3;

    logic [4:0] keys;
    logic       in_fight;
    logic       timer_start;
    logic       attack_done;
    logic [7:0] sel_damage;
    logic [7:0] defender_hp;

    assign keys     = {key_U, key_D, key_L, key_R, key_C};
    assign in_fight = (scene_state == SCENE_FIGHT);

    // Arm the hold timer on the same edge that enters ATTACK
    assign timer_start = (state == ST_SELECT) && in_fight && (keys == PRESS_C);

    attack_timer #(
        .ATTACK_CYCLES (ATTACK_CYCLES)
    ) u_attack_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (attack_done)
    );

    // Damage of the highlighted skill for whichever player is acting
    always_comb begin
        sel_damage = '0;
        case (skill_cursor)
            2'd1:    sel_damage = turn ? p2_dmg_1 : p1_dmg_1;
            2'd2:    sel_damage = turn ? p2_dmg_2 : p1_dmg_2;
            2'd3:    sel_damage = turn ? p2_dmg_3 : p1_dmg_3;
            default: sel_damage = '0;
        endcase
    end

    // The defender is whoever is not acting this turn
    always_comb begin
        defender_hp = turn ? p1_cur_hp : p2_cur_hp;
    end

    // Status flags follow the registered state directly
    assign attacking  = (state == ST_ATTACK);
    assign fight_done = (state == ST_DONE);

    // Fight sequencing and all registered fight data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            p1_cur_hp    <= '0;
            p2_cur_hp    <= '0;
            turn         <= 1'b0;
            skill_cursor <= 2'd1;
            last_damage  <= '0;
            winner       <= WINNER_NONE;
            p1_dmg_1     <= '0;
            p1_dmg_2     <= '0;
            p1_dmg_3     <= '0;
            p2_dmg_1     <= '0;
            p2_dmg_2     <= '0;
            p2_dmg_3     <= '0;
        end else if ((state != ST_IDLE) && !in_fight) begin
            // Leaving the fight scene aborts whatever was in progress,
            // including a pending damage application on the last hold cycle
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fight) begin
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    p1_cur_hp    <= p1_pokemon_hp;
                    p2_cur_hp    <= p2_pokemon_hp;
                    p1_dmg_1     <= p1_skill_1_damage;
                    p1_dmg_2     <= p1_skill_2_damage;
                    p1_dmg_3     <= p1_skill_3_damage;
                    p2_dmg_1     <= p2_skill_1_damage;
                    p2_dmg_2     <= p2_skill_2_damage;
                    p2_dmg_3     <= p2_skill_3_damage;
                    last_damage  <= '0;
                    winner       <= WINNER_NONE;
                    skill_cursor <= 2'd1;
                    turn         <= (p1_pokemon_speed >= p2_pokemon_speed) ? 1'b0 : 1'b1;
                    state        <= ST_SELECT;
                end

                ST_SELECT: begin
                    case (keys)
                        PRESS_U, PRESS_L: begin
                            if (skill_cursor > 2'd1) begin
                                skill_cursor <= skill_cursor - 2'd1;
                            end
                        end
                        PRESS_D, PRESS_R: begin
                            if (skill_cursor < 2'd3) begin
                                skill_cursor <= skill_cursor + 2'd1;
                            end
                        end
                        PRESS_C: begin
                            last_damage <= sel_damage;
                            state       <= ST_ATTACK;
                        end
                        default: ;
                    endcase
                end

                ST_ATTACK: begin
                    if (attack_done) begin
                        if (turn) begin
                            p1_cur_hp <= sat_sub(p1_cur_hp, last_damage);
                        end else begin
                            p2_cur_hp <= sat_sub(p2_cur_hp, last_damage);
                        end
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (defender_hp == 8'd0) begin
                        winner <= turn ? WINNER_P2 : WINNER_P1;
                        state  <= ST_DONE;
                    end else begin
                        turn         <= ~turn;
                        skill_cursor <= 2'd1;
                        state        <= ST_SELECT;
                    end
                end

                ST_DONE: ;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
